// File: rtl/if_batch_fetch_pkg.sv
// Shared definitions for the batch fetch unit.
// Holds the default address width, batch size, reset PC and PC step. It also holds the
// JAL/BRANCH opcodes, the fetch FSM state encodings and the J/B immediate decoders.
package if_batch_fetch_pkg;

  localparam int unsigned INST_ADDR_WIDTH = 32;
  localparam int unsigned IF_BATCH_SIZE   = 4;
  localparam logic [31:0] INST_INIT_PC    = 32'h0000_0000;
  localparam int unsigned INST_ADD_STEP   = 4;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // Fetch FSM encodings
  localparam logic [1:0] StReq  = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StHold = 2'd2;

  function automatic logic [31:0] j_imm(input logic [31:0] inst);
    return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

  function automatic logic [31:0] b_imm(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/if_batch_fetch_static_predictor.sv
// if_static_predictor: combinational static branch predictor for one fetch block.
// Predicts JAL and backward conditional branches as taken. The lowest taken lane inside the
// start mask wins.
//   blk_data_i  lane-packed block instructions
//   mask_i      start mask (lanes at/after the fetch PC)
//   blk_pc_i    block address
//   taken_o     one-hot predicted-taken lane (zero when nothing predicted)
//   mask_o      mask trimmed after the taken lane
//   target_o    lane PC + sign-extended J/B immediate of the taken lane
module if_static_predictor
  import if_batch_fetch_pkg::*;
#(
  parameter int unsigned XLEN  = INST_ADDR_WIDTH,
  parameter int unsigned BATCH = IF_BATCH_SIZE
) (
  input  logic [BATCH*32-1:0] blk_data_i,
  input  logic [BATCH-1:0]    mask_i,
  input  logic [XLEN-1:0]     blk_pc_i,
  output logic [BATCH-1:0]    taken_o,
  output logic [BATCH-1:0]    mask_o,
  output logic [XLEN-1:0]     target_o
);

  always_comb begin
    logic        found;
    logic [31:0] inst;
    logic [31:0] imm;
    logic        is_jal;
    logic        is_bwd;
    taken_o  = '0;
    mask_o   = mask_i;
    target_o = '0;
    found    = 1'b0;
    for (int i = 0; i < BATCH; i++) begin
      inst   = blk_data_i[i*32 +: 32];
      is_jal = (inst[6:0] == OPC_JAL);
      is_bwd = (inst[6:0] == OPC_BRANCH) && inst[31];
      imm    = is_jal ? j_imm(inst) : b_imm(inst);
      if (found) begin
        mask_o[i] = 1'b0;
      end else if (mask_i[i] && (is_jal || is_bwd)) begin
        found      = 1'b1;
        taken_o[i] = 1'b1;
        target_o   = blk_pc_i + XLEN'(INST_ADD_STEP * i) + XLEN'($signed(imm));
      end
    end
  end

endmodule

// File: rtl/if_batch_fetch.sv
// if_batch_fetch: batch instruction fetch unit.
// Issues block-aligned requests with at most one outstanding. Holds one returned block in a
// single-entry output register and presents it with a lane-valid mask.
// Optional static prediction is enabled by defining IF_STATIC_PREDICT_EN.
//   clk, rst                synchronous active-high reset
//   redirect_valid/_pc      flush and restart fetch
//   imem_req_*              block request handshake
//   imem_resp_*             in-order block data, one per accepted request
//   out_*                   batch handshake to consumer (pc, inst, mask, pred_taken)
module if_batch_fetch
  import if_batch_fetch_pkg::*;
#(
  parameter int unsigned     XLEN      = INST_ADDR_WIDTH,
  parameter int unsigned     BATCH     = IF_BATCH_SIZE,
  parameter logic [XLEN-1:0] INST_INIT = XLEN'(INST_INIT_PC)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                redirect_valid,
  input  logic [XLEN-1:0]     redirect_pc,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [XLEN-1:0]     imem_req_addr,
  input  logic                imem_resp_valid,
  input  logic [BATCH*32-1:0] imem_resp_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_pc,
  output logic [BATCH*32-1:0] out_inst,
  output logic [BATCH-1:0]    out_mask,
  output logic [BATCH-1:0]    out_pred_taken
);

  localparam int unsigned     BlkBytes = INST_ADD_STEP * BATCH;
  localparam logic [XLEN-1:0] BlkMask  = ~XLEN'(BlkBytes - 1);
  localparam logic [XLEN-1:0] LaneMask = XLEN'(BATCH - 1);

  logic [1:0]          state_q, state_d;
  logic [XLEN-1:0]     pc_q, pc_d;
  logic                drop_q, drop_d;
  logic                out_valid_q, out_valid_d;
  logic [XLEN-1:0]     out_pc_q, out_pc_d;
  logic [BATCH*32-1:0] out_inst_q, out_inst_d;
  logic [BATCH-1:0]    out_mask_q, out_mask_d;
  logic [BATCH-1:0]    out_pred_q, out_pred_d;

  logic [XLEN-1:0]     blk_addr, lane_sel, pred_target;
  logic [BATCH-1:0]    start_mask, pred_mask, pred_taken;
  logic                req_fire, out_fire;

  assign blk_addr = pc_q & BlkMask;
  assign lane_sel = (pc_q >> 2) & LaneMask;

  always_comb begin
    start_mask = '0;
    for (int i = 0; i < BATCH; i++) begin
      start_mask[i] = (XLEN'(i) >= lane_sel);
    end
  end

`ifdef IF_STATIC_PREDICT_EN
  if_static_predictor #(
    .XLEN  (XLEN),
    .BATCH (BATCH)
  ) u_pred (
    .blk_data_i (imem_resp_data),
    .mask_i     (start_mask),
    .blk_pc_i   (blk_addr),
    .taken_o    (pred_taken),
    .mask_o     (pred_mask),
    .target_o   (pred_target)
  );
`else
  assign pred_taken  = '0;
  assign pred_mask   = start_mask;
  assign pred_target = '0;
`endif

  // Requests only go out when the response is guaranteed a free output slot, and never while
  // a stale response is still owed (keeps a single outstanding request).
  assign imem_req_valid = ~rst & (state_q == StReq) & ~drop_q & (~out_valid_q | out_ready);
  assign imem_req_addr  = blk_addr;
  assign req_fire       = imem_req_valid & imem_req_ready;
  assign out_fire       = out_valid_q & out_ready;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_d      = drop_q;
    out_valid_d = out_valid_q;
    out_pc_d    = out_pc_q;
    out_inst_d  = out_inst_q;
    out_mask_d  = out_mask_q;
    out_pred_d  = out_pred_q;

    if (out_fire) out_valid_d = 1'b0;

    case (state_q)
      StReq: begin
        if (req_fire) state_d = StWait;
        // Stale response from before a redirect
        if (drop_q && imem_resp_valid) drop_d = 1'b0;
      end
      StWait: begin
        if (imem_resp_valid) begin
          out_valid_d = 1'b1;
          out_pc_d    = blk_addr;
          out_inst_d  = imem_resp_data;
          out_mask_d  = pred_mask;
          out_pred_d  = pred_taken;
          pc_d        = (|pred_taken) ? pred_target : blk_addr + XLEN'(BlkBytes);
          state_d     = out_ready ? StReq : StHold;
        end
      end
      StHold: begin
        if (out_fire) state_d = StReq;
      end
      default: state_d = StReq;
    endcase

    if (redirect_valid) begin
      pc_d        = redirect_pc & ~XLEN'(3);
      out_valid_d = 1'b0;
      out_mask_d  = '0;
      out_pred_d  = '0;
      // A response arriving this cycle is consumed here, so only still-owed ones need dropping.
      drop_d      = (drop_q & ~imem_resp_valid) | req_fire |
                    ((state_q == StWait) & ~imem_resp_valid);
      state_d     = StReq;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StReq;
      pc_q        <= INST_INIT;
      drop_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_pc_q    <= INST_INIT;
      out_inst_q  <= '0;
      out_mask_q  <= '0;
      out_pred_q  <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_q      <= drop_d;
      out_valid_q <= out_valid_d;
      out_pc_q    <= out_pc_d;
      out_inst_q  <= out_inst_d;
      out_mask_q  <= out_mask_d;
      out_pred_q  <= out_pred_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_pc         = out_pc_q;
  assign out_inst       = out_inst_q;
  assign out_mask       = out_mask_q;
  assign out_pred_taken = out_pred_q;

endmodule

// File: tb/tb_if_batch_fetch.sv
// Testbench for if_batch_fetch: random-latency memory model, scoreboard of expected batches
// built from the fetch rules, and a monitor that checks every accepted batch.
module tb_if_batch_fetch;

  logic         clk = 1'b0;
  logic         rst;
  logic         redirect_valid;
  logic [31:0]  redirect_pc;
  logic         imem_req_valid;
  logic         imem_req_ready;
  logic [31:0]  imem_req_addr;
  logic         imem_resp_valid;
  logic [127:0] imem_resp_data;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_pc;
  logic [127:0] out_inst;
  logic [3:0]   out_mask;
  logic [3:0]   out_pred_taken;

  always #5 clk = ~clk;

  if_batch_fetch #(
    .XLEN      (32),
    .BATCH     (4),
    .INST_INIT (32'h0)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_inst        (out_inst),
    .out_mask        (out_mask),
    .out_pred_taken  (out_pred_taken)
  );

  typedef struct {
    logic [31:0]  pc;
    logic [3:0]   mask;
    logic [127:0] inst;
    logic [3:0]   pred;
  } batch_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  batch_t      exp_q[$];
  pend_t       pend_q[$];
  logic [31:0] fired_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_fire   = 0;
  int          lat_min  = 0;
  int          lat_max  = 0;
  int          rdy_pct  = 100;
  int          cyc      = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: condition not reached", name);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
`ifdef IF_STATIC_PREDICT_EN
    if (a == 32'h204) return 32'h0400_006F;  // jal x0, +0x40
`endif
    return ((a ^ 32'h5A5A_0000) << 7) | 32'h13;  // opcode OP-IMM: never predicted
  endfunction

  // Expected batch sequence from a fetch PC: aligned block, lanes from the start word on,
  // then the next block (or the predicted target).
  task automatic build_stream(input logic [31:0] start, input int n);
    logic [31:0] pc, blk, nxt, w, imm;
    int          s;
    bit          stop;
    batch_t      b;
    exp_q.delete();
    pc = start;
    for (int k = 0; k < n; k++) begin
      blk    = pc & 32'hFFFF_FFF0;
      s      = int'((pc >> 2) & 32'h3);
      b.pc   = blk;
      b.mask = '0;
      b.pred = '0;
      nxt    = blk + 32'd16;
      stop   = 1'b0;
      for (int i = 0; i < 4; i++) begin
        w = mem_word(blk + 32'(4 * i));
        b.inst[i*32 +: 32] = w;
        if (i >= s && !stop) begin
          b.mask[i] = 1'b1;
`ifdef IF_STATIC_PREDICT_EN
          if (w[6:0] == 7'b1101111) begin
            imm = {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
            b.pred[i] = 1'b1;
            stop = 1'b1;
            nxt = blk + 32'(4 * i) + imm;
          end else if (w[6:0] == 7'b1100011 && w[31]) begin
            imm = {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
            b.pred[i] = 1'b1;
            stop = 1'b1;
            nxt = blk + 32'(4 * i) + imm;
          end
`else
          imm = '0;
          w   = w + imm;
`endif
        end
      end
      exp_q.push_back(b);
      pc = nxt;
    end
  endtask

  // Memory: in-order responses, latency lat_min..lat_max cycles after the accepting cycle.
  initial begin
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
  end

  always begin
    logic        s_fire, s_resp, s_rst;
    logic [31:0] s_addr, a;
    @(negedge clk);
    s_fire = imem_req_valid & imem_req_ready;
    s_resp = imem_resp_valid;
    s_rst  = rst;
    s_addr = imem_req_addr;
    @(posedge clk);
    #1;
    cyc++;
    if (s_rst) begin
      pend_q.delete();
    end else begin
      if (s_resp && pend_q.size() > 0) void'(pend_q.pop_front());
      if (s_fire) begin
        pend_q.push_back('{s_addr, cyc + lat_min + int'($urandom_range(lat_max - lat_min, 0))});
        fired_q.push_back(s_addr);
      end
    end
    imem_req_ready = ($urandom_range(99, 0) < rdy_pct);
    if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      a = pend_q[0].addr;
      imem_resp_valid = 1'b1;
      for (int i = 0; i < 4; i++) imem_resp_data[i*32 +: 32] = mem_word(a + 32'(4 * i));
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
    end
  end

  // Monitor: scoreboard compare on every accepted batch, plus hold/flush behaviour.
  logic   prev_hold  = 1'b0;
  logic   prev_redir = 1'b0;
  batch_t held;

  always @(negedge clk) begin
    batch_t e;
    if (rst) begin
      prev_hold  = 1'b0;
      prev_redir = 1'b0;
    end else begin
      if (prev_redir) begin
        check("flush_clears_valid", out_valid, 1'b0);
      end else if (prev_hold) begin
        check("hold_valid", out_valid, 1'b1);
        check("hold_pc", out_pc, held.pc);
        check("hold_inst", out_inst, held.inst);
        check("hold_mask", out_mask, held.mask);
      end
      if (out_valid && !out_ready) check("no_req_while_held", imem_req_valid, 1'b0);
      if (out_valid && out_ready) begin
        n_fire++;
        if (exp_q.size() == 0) begin
          fail_now("scoreboard_empty");
        end else begin
          e = exp_q.pop_front();
          check("batch_pc", out_pc, e.pc);
          check("batch_mask", out_mask, e.mask);
          check("batch_inst", out_inst, e.inst);
          check("batch_pred", out_pred_taken, e.pred);
        end
      end
      prev_redir = redirect_valid;
      prev_hold  = out_valid & ~out_ready & ~redirect_valid;
      held.pc    = out_pc;
      held.inst  = out_inst;
      held.mask  = out_mask;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    @(negedge clk);
    #1;
    build_stream(pc & 32'hFFFF_FFFC, 600);
    step();
    redirect_valid = 1'b0;
  endtask

  task automatic wait_out_valid(input string name);
    int t = 0;
    while (!out_valid && t < 40) begin
      step();
      t++;
    end
    if (!out_valid) fail_now(name);
  endtask

  task automatic check_reset_values();
    check("rst_req_valid", imem_req_valid, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_mask", out_mask, 4'b0);
    check("rst_out_pred", out_pred_taken, 4'b0);
    check("rst_out_pc", out_pc, 32'h0);
  endtask

  initial begin
    int base, t, nf;
    bit hit;
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    out_ready = 1'b1;
    repeat (3) step();
    check_reset_values();
    build_stream(32'h0, 600);
    rst = 1'b0;
    @(negedge clk);
    check("first_req_valid", imem_req_valid, 1'b1);
    check("first_req_addr", imem_req_addr, 32'h0);
    base = n_fire;
    repeat (12) step();
    check("steady_rate_ge5", (n_fire - base) >= 5, 1'b1);

    // Redirect while a response is outstanding
    lat_min = 3;
    lat_max = 3;
    hit = 1'b0;
    for (int i = 0; i < 30 && !hit; i++) begin
      step();
      if (imem_req_valid && imem_req_ready) hit = 1'b1;
    end
    if (!hit) fail_now("wait_req_fire");
    step();
    do_redirect(32'h108);
    wait_out_valid("redirect_batch_timeout");
    check("redirect_out_pc", out_pc, 32'h100);
    check("redirect_out_mask", out_mask, 4'b1100);

    // Back-pressure
    lat_min = 0;
    lat_max = 0;
    step();
    wait_out_valid("hold_batch_timeout");
    out_ready = 1'b0;
    nf = fired_q.size();
    repeat (5) step();
    check("hold_no_requests", fired_q.size() - nf, 0);
    out_ready = 1'b1;
    repeat (6) step();
    check("resume_after_ready", fired_q.size() > nf, 1'b1);

    // Address-space wrap
    do_redirect(32'hFFFF_FFF0);
    fired_q.delete();
    repeat (8) step();
    if (fired_q.size() >= 2) begin
      check("wrap_first_addr", fired_q[0], 32'hFFFF_FFF0);
      check("wrap_next_addr", fired_q[1], 32'h0);
    end else fail_now("wrap_requests");

    // Response and redirect in the same cycle
    lat_min = 2;
    lat_max = 2;
    hit = 1'b0;
    for (int i = 0; i < 30 && !hit; i++) begin
      step();
      if (imem_resp_valid) hit = 1'b1;
    end
    if (!hit) fail_now("wait_resp");
    fired_q.delete();
    do_redirect(32'h300);
    check("same_cycle_squash", out_valid, 1'b0);
    repeat (2) step();
    check("same_cycle_req_count", fired_q.size(), 1);
    if (fired_q.size() > 0) check("same_cycle_req_addr", fired_q[0], 32'h300);
    wait_out_valid("same_cycle_batch_timeout");
    check("same_cycle_out_pc", out_pc, 32'h300);

`ifdef IF_STATIC_PREDICT_EN
    lat_min = 0;
    lat_max = 0;
    do_redirect(32'h200);
    wait_out_valid("pred_batch_timeout");
    check("pred_pc", out_pc, 32'h200);
    check("pred_mask", out_mask, 4'b0011);
    check("pred_taken", out_pred_taken, 4'b0010);
    repeat (6) step();
`endif

    // Random traffic with random redirects
    lat_min = 0;
    lat_max = 3;
    rdy_pct = 70;
    base = n_fire;
    for (int i = 0; i < 1500; i++) begin
      out_ready = ($urandom_range(99, 0) < 75);
      if ($urandom_range(99, 0) < 2) begin
        do_redirect($urandom_range(32'h0FFF, 0));
        if ($urandom_range(1, 0) == 1) do_redirect($urandom);
      end else begin
        step();
      end
    end
    check("random_traffic_flowed", (n_fire - base) > 100, 1'b1);

    // Reset in the middle of traffic
    rst = 1'b1;
    step();
    check_reset_values();
    step();
    build_stream(32'h0, 600);
    rst = 1'b0;
    out_ready = 1'b1;
    base = n_fire;
    t = 0;
    while (n_fire == base && t < 40) begin
      step();
      t++;
    end
    check("post_reset_fetch", n_fire > base, 1'b1);
    repeat (20) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
